// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared widths and request/result types for the shift request queue
package shift_pkg;

    localparam int SHIFT_DATA_W = 16;
    localparam int SHIFT_AMT_W  = 4;

    typedef struct packed {
        logic [SHIFT_DATA_W-1:0] data;
        logic [SHIFT_AMT_W-1:0]  amt;
        logic                    rot;
    } shift_req_t;

    // FIFO entries only carry the rotate flag when rotation is built in.
`ifdef ROTATE_EN
    typedef shift_req_t shift_entry_t;
`else
    typedef struct packed {
        logic [SHIFT_DATA_W-1:0] data;
        logic [SHIFT_AMT_W-1:0]  amt;
    } shift_entry_t;
`endif

    typedef logic [SHIFT_DATA_W-1:0] shift_result_t;

endpackage

// File: rtl/Right_Barrel_Shifter.sv
// rtl/Right_Barrel_Shifter.sv - 16-bit combinational logical right barrel shifter
module Right_Barrel_Shifter
    import shift_pkg::*;
(
    input  logic [SHIFT_DATA_W-1:0] data,
    input  logic [SHIFT_AMT_W-1:0]  control,
    output logic [SHIFT_DATA_W-1:0] result
);

    logic [SHIFT_DATA_W-1:0] s1, s2, s4;

    always_comb begin
        s1     = control[0] ? {1'b0, data[15:1]} : data;
        s2     = control[1] ? {2'b0, s1[15:2]}   : s1;
        s4     = control[2] ? {4'b0, s2[15:4]}   : s2;
        result = control[3] ? {8'b0, s4[15:8]}   : s4;
    end

endmodule

// File: rtl/shift_request_queue.sv
// rtl/shift_request_queue.sv - request FIFO + registered result around the barrel shifter; optional ROTATE_EN
module shift_request_queue
    import shift_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = SHIFT_DATA_W,
    parameter int AMT_W  = SHIFT_AMT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [AMT_W-1:0]  in_amt,
    input  logic              in_rot,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [AMT_W-1:0]  out_amt,
    output logic              busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

    shift_entry_t  mem [DEPTH];
    shift_entry_t  wr_entry;
    shift_entry_t  head;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          push, pop;
    shift_result_t sh_res;
    shift_result_t load_val;

    assign in_ready = (count != CNT_FULL);
    assign push     = in_valid && in_ready;
    assign pop      = (count != '0) && (!out_valid || out_ready);
    assign busy     = (count != '0) || out_valid;
    assign head     = mem[rd_ptr];

`ifdef ROTATE_EN
    assign wr_entry = '{data: in_data, amt: in_amt, rot: in_rot};
    // Bits shifted out on the right wrap into the top; amt 0 shifts by 16 and contributes nothing.
    assign load_val = sh_res | (head.rot ? (head.data << (5'd16 - {1'b0, head.amt})) : '0);
`else
    logic unused_rot;
    assign unused_rot = in_rot;
    assign wr_entry   = '{data: in_data, amt: in_amt};
    assign load_val   = sh_res;
`endif

    Right_Barrel_Shifter u_shifter (
        .data    (head.data),
        .control (head.amt),
        .result  (sh_res)
    );

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    // Output register: reload on pop, otherwise drop valid once consumed and keep the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_amt   <= '0;
        end else if (pop) begin
            out_valid <= 1'b1;
            out_data  <= load_val;
            out_amt   <= head.amt;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_request_queue.sv
// tb/tb_shift_request_queue.sv - randomized, model-checked bench for shift_request_queue
module tb_shift_request_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic [3:0]  in_amt = '0;
    logic        in_rot = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [3:0]  out_amt;
    logic        busy;

    shift_request_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_amt(in_amt), .in_rot(in_rot),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_amt(out_amt), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        int amt;
        bit rot;
    } req_s;

    int   total = 0;
    int   bad = 0;
    req_s mq[$];
    bit   m_ov;
    int   m_od, m_oa;
    int   got[$];
    int   got_amt[$];
    int   acc_amt[$];
    int   accepts;

    function automatic int ref_res(int d, int a, bit r);
        int  res;
        bit  eff;
`ifdef ROTATE_EN
        eff = r;
`else
        eff = 1'b0 & r;
`endif
        res = d >> a;
        if (eff && a != 0) res = (res | (d << (16 - a))) & 'hFFFF;
        return res;
    endfunction

    function automatic void model_clear();
        mq.delete();
        m_ov = 1'b0;
        m_od = 0;
        m_oa = 0;
    endfunction

    // Called at posedge+1; drives one cycle of inputs, advances model, checks outputs after the edge.
    task automatic cycle(bit v, int d, int a, bit r, bit ordy);
        bit   m_push, m_pop;
        req_s e;
        in_valid = v; in_data = d[15:0]; in_amt = a[3:0]; in_rot = r; out_ready = ordy;
        #1;
        total++;
        if (in_ready !== (mq.size() != DEPTH)) begin
            bad++; $display("FAIL in_ready got=%b exp=%b", in_ready, mq.size() != DEPTH);
        end
        if (out_valid && ordy) begin
            got.push_back(int'(out_data));
            got_amt.push_back(int'(out_amt));
        end
        m_push = v && (mq.size() != DEPTH);
        m_pop  = (mq.size() != 0) && (!m_ov || ordy);
        if (m_pop) begin
            e = mq.pop_front();
            m_od = ref_res(e.data, e.amt, e.rot);
            m_oa = e.amt;
            m_ov = 1'b1;
        end else if (m_ov && ordy) begin
            m_ov = 1'b0;
        end
        if (m_push) begin
            e.data = d & 'hFFFF; e.amt = a & 15; e.rot = r;
            mq.push_back(e);
            accepts++;
            acc_amt.push_back(a & 15);
        end
        @(posedge clk); #1;
        total++;
        if (out_valid !== m_ov) begin
            bad++; $display("FAIL out_valid got=%b exp=%b", out_valid, m_ov);
        end
        total++;
        if (out_data !== m_od[15:0]) begin
            bad++; $display("FAIL out_data got=%h exp=%h", out_data, m_od[15:0]);
        end
        total++;
        if (out_amt !== m_oa[3:0]) begin
            bad++; $display("FAIL out_amt got=%0d exp=%0d", out_amt, m_oa);
        end
        total++;
        if (busy !== (mq.size() != 0 || m_ov)) begin
            bad++; $display("FAIL busy got=%b exp=%b", busy, mq.size() != 0 || m_ov);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (mq.size() != 0 || m_ov); i++) cycle(0, 0, 0, 0, 1);
        total++;
        if (mq.size() != 0 || m_ov) begin
            bad++; $display("FAIL drain_timeout got=%0d exp=0", mq.size());
        end
    endtask

    task automatic clear_logs();
        got.delete(); got_amt.delete(); acc_amt.delete(); accepts = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_data !== 16'h0 || out_amt !== 4'h0) begin
            bad++; $display("FAIL reset_state got=%b%b%b/%h/%h exp=010/0000/0", out_valid, in_ready, busy, out_data, out_amt);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_clear();
        clear_logs();
    endtask

    task automatic test_pattern();
        int amts[9] = '{0, 1, 2, 4, 8, 12, 6, 11, 15};
        int exp_tab[9] = '{'hAAAA, 'h5555, 'h2AAA, 'h0AAA, 'h00AA, 'h000A, 'h02AA, 'h0015, 'h0001};
        clear_logs();
        for (int i = 0; i < 9; i++) cycle(1, 'hAAAA, amts[i], 0, 1);
        drain();
        total++;
        if (got.size() != 9) begin
            bad++; $display("FAIL pattern_count got=%0d exp=9", got.size());
        end
        for (int i = 0; i < 9 && i < got.size(); i++) begin
            total++;
            if (got[i] != exp_tab[i]) begin
                bad++; $display("FAIL pattern_%0d got=%h exp=%h", i, got[i], exp_tab[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        clear_logs();
        for (int i = 0; i < 7; i++) begin
            cycle(1, 'h1234, 4, 0, 0);
            if (out_valid) begin
                total++;
                if (out_data !== 16'h0123) begin
                    bad++; $display("FAIL bp_hold got=%h exp=0123", out_data);
                end
            end
        end
        total++;
        if (accepts != 5) begin
            bad++; $display("FAIL bp_accepts got=%0d exp=5", accepts);
        end
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL bp_full got=%b exp=0", in_ready);
        end
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 1);
        total++;
        if (got.size() != 5) begin
            bad++; $display("FAIL bp_drain got=%0d exp=5", got.size());
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL bp_busy got=%b exp=0", busy);
        end
    endtask

    task automatic check_order(string tag);
        total++;
        if (got_amt.size() != acc_amt.size()) begin
            bad++; $display("FAIL %s_count got=%0d exp=%0d", tag, got_amt.size(), acc_amt.size());
        end
        for (int i = 0; i < got_amt.size() && i < acc_amt.size(); i++) begin
            total++;
            if (got_amt[i] != acc_amt[i]) begin
                bad++; $display("FAIL %s_order_%0d got=%0d exp=%0d", tag, i, got_amt[i], acc_amt[i]);
            end
        end
    endtask

    task automatic test_simultaneous();
        bit r;
        clear_logs();
        for (int i = 0; i < 3; i++) cycle(1, $urandom, $urandom_range(0, 15), 0, 0);
        for (int i = 0; i < 40; i++) begin
            r = i[0];
            cycle(r, $urandom, $urandom_range(0, 15), 0, r);
        end
        drain();
        check_order("simul");
    endtask

    task automatic test_random();
        clear_logs();
        for (int i = 0; i < 300; i++)
            cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 15),
                  $urandom_range(0, 1), $urandom_range(0, 2) != 0);
        drain();
        check_order("rand");
    endtask

    task automatic test_rotate();
        int exp_tab[3];
`ifdef ROTATE_EN
        exp_tab = '{'hC000, 'h4000, 'hFF00};
`else
        exp_tab = '{'h4000, 'h4000, 'h0F00};
`endif
        clear_logs();
        cycle(1, 'h8001, 1, 1, 1);
        cycle(1, 'h8001, 1, 0, 1);
        cycle(1, 'hF00F, 4, 1, 1);
        drain();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (i >= got.size() || got[i] != exp_tab[i]) begin
                bad++; $display("FAIL rotate_%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : -1, exp_tab[i]);
            end
        end
    endtask

    task automatic test_reset_midop();
        for (int i = 0; i < 3; i++) cycle(1, $urandom, $urandom_range(1, 15), 0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_data !== 16'h0) begin
            bad++; $display("FAIL midreset got=%b%b%b/%h exp=010/0000", out_valid, in_ready, busy, out_data);
        end
        model_clear();
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_logs();
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 1);
        total++;
        if (got.size() != 0) begin
            bad++; $display("FAIL stale_result got=%0d exp=0", got.size());
        end
    endtask

    initial begin
        model_clear();
        #1;
        test_reset();
        test_pattern();
        test_backpressure();
        test_simultaneous();
        test_rotate();
        test_random();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
